// File: rtl/sync_cs_ctrl_if.sv
// Host-side request/response channel of the synchronous CS memory initiator.
// master = request path inside the memory controller, slave = sync_cs_ctrl.
interface sync_cs_ctrl_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/sync_cs_ctrl.sv
// Initiator for the synchronous chip-select memory bus: one word per request,
// strobes held for the device latency, acknowledge-gated completion and a
// bounded strobe length that aborts unacknowledged accesses.
module sync_cs_ctrl #(
    parameter int unsigned RD_LAT = 6,
    parameter int unsigned WR_LAT = 5,
    parameter int unsigned TO_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_,
    sync_cs_ctrl_if.slave host,
    output logic [15:0]   mc_addr,
    inout  wire  [31:0]   mc_dq,
    output logic          mc_cs_,
    output logic          mc_we_,
    output logic          mc_oe_,
    input  logic          mc_ack_
);

    localparam int unsigned NW = $clog2(TO_CYC + 1);
    localparam logic [NW-1:0] RD_N = NW'(RD_LAT);
    localparam logic [NW-1:0] WR_N = NW'(WR_LAT);
    localparam logic [NW-1:0] TO_N = NW'(TO_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_RECOVER
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic [15:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [NW-1:0] r_n;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_cap;
    logic [31:0]   r_rdata;

    logic          w_start;
    logic          w_ok;
    logic          w_timeout;
    logic          w_ack_now;
    logic [NW-1:0] w_lat;
    logic          w_drive;

    // Sticky acknowledge including this cycle's sample, and the per-direction latency floor
    assign w_ack_now = r_ack | mc_ack_;
    assign w_lat     = r_we ? WR_N : RD_N;

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, leave STROBE on ack+latency or timeout, one RECOVER cycle
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_ok      = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host.req) begin
                    w_start = 1'b1;
                    w_next  = S_STROBE;
                end
            end
            S_STROBE: begin
                if (w_ack_now && (r_n >= w_lat)) begin
                    w_ok   = 1'b1;
                    w_next = S_RECOVER;
                end else if (r_n == TO_N) begin
                    w_timeout = 1'b1;
                    w_next    = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, strobe counter, ack flag, read capture and error flag
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_n     <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_cap   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_we    <= host.we;
                r_addr  <= host.addr;
                r_wdata <= host.wdata;
                r_n     <= NW'(1);
                r_ack   <= 1'b0;
                r_err   <= 1'b0;
            end else if (r_state == S_STROBE) begin
                r_ack <= w_ack_now;
                r_err <= w_timeout;
                if (w_next == S_STROBE) begin
                    r_n <= r_n + NW'(1);
                end
                if (!r_we && (r_n == RD_N)) begin
                    r_cap <= mc_dq;
                end
                // Data is sampled at RD_LAT into a shadow and only published on a
                // successful completion, so a timed-out read leaves rdata untouched.
                if (w_ok && !r_we) begin
                    r_rdata <= (r_n == RD_N) ? mc_dq : r_cap;
                end
            end
        end
    end

    // Bus strobes and write-data enable decoded from the registered state
    always_comb begin
        mc_cs_  = 1'b1;
        mc_we_  = 1'b1;
        mc_oe_  = 1'b1;
        w_drive = 1'b0;
        if (r_state == S_STROBE) begin
            mc_cs_ = 1'b0;
            if (r_we) begin
                mc_we_  = 1'b0;
                w_drive = 1'b1;
            end else begin
                mc_oe_ = 1'b0;
            end
        end
    end

    assign mc_addr    = r_addr;
    assign mc_dq      = w_drive ? r_wdata : 'z;

    assign host.busy  = (r_state != S_IDLE);
    assign host.done  = (r_state == S_RECOVER);
    assign host.err   = (r_state == S_RECOVER) && r_err;
    assign host.rdata = r_rdata;

endmodule

// File: tb/tb_sync_cs_ctrl.sv
// Directed bench for sync_cs_ctrl with a behavioural CS device and a
// scoreboard of expected completions.
module tb_sync_cs_ctrl;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [15:0] mc_addr;
    wire  [31:0] mc_dq;
    logic        mc_cs_;
    logic        mc_we_;
    logic        mc_oe_;
    logic        mc_ack_;

    sync_cs_ctrl_if hif();

    sync_cs_ctrl #(.RD_LAT(6), .WR_LAT(5), .TO_CYC(64)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .host    (hif.slave),
        .mc_addr (mc_addr),
        .mc_dq   (mc_dq),
        .mc_cs_  (mc_cs_),
        .mc_we_  (mc_we_),
        .mc_oe_  (mc_oe_),
        .mc_ack_ (mc_ack_)
    );

    always #5 clk = ~clk;

    // Device model: ack from cycle ack_from, read data from cycle 6
    // (incrementing afterwards so a late capture is visible), write commit at end of cycle 5.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    logic [31:0] dev_mem [256];
    bit          dev_vld [256];
    int unsigned dev_cnt  = 0;
    int unsigned ack_from = 4;
    logic [31:0] dev_word;

    always @(posedge clk) begin
        if (!mc_cs_) begin
            if (!mc_we_ && dev_cnt == 4) begin
                dev_mem[mc_addr[7:0]] <= mc_dq;
                dev_vld[mc_addr[7:0]] <= 1'b1;
            end
            dev_cnt <= dev_cnt + 1;
        end else begin
            dev_cnt <= 0;
        end
    end

    always_comb dev_word = dev_vld[mc_addr[7:0]] ? dev_mem[mc_addr[7:0]] : init_val(mc_addr[7:0]);
    assign mc_dq   = (!mc_cs_ && !mc_oe_ && dev_cnt >= 5) ? dev_word + 32'(dev_cnt - 5) : 32'hzzzz_zzzz;
    assign mc_ack_ = !mc_cs_ && ((dev_cnt + 1) >= ack_from);

    // Bus monitor: strobe lengths, cs_-high gaps, strobe and done counts
    int unsigned cyc_cnt = 0, cs_run = 0, we_run = 0, hi_run = 0;
    int unsigned last_cs_len = 0, last_we_len = 0, last_gap = 0, n_strobes = 0, done_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (!mc_cs_) begin
            cs_run <= cs_run + 1;
            if (cs_run == 0) begin
                last_gap  <= hi_run;
                n_strobes <= n_strobes + 1;
            end
            hi_run <= 0;
        end else begin
            if (cs_run != 0) last_cs_len <= cs_run;
            cs_run <= 0;
            hi_run <= hi_run + 1;
        end
        if (!mc_we_) begin
            we_run <= we_run + 1;
        end else begin
            if (we_run != 0) last_we_len <= we_run;
            we_run <= 0;
        end
        if (hif.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Scoreboard
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
    } sb_t;

    sb_t sb_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_last = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int unsigned exp_lat,
                          input bit keep_req, input bit toggle, output int unsigned t_done);
        sb_t e;
        sb_t got_e;
        int unsigned k;
        bit got;
        hif.req   = 1'b1;
        hif.we    = wr;
        hif.addr  = a;
        hif.wdata = d;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        k   = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1 && !keep_req) hif.req = 1'b0;
            if (toggle && k == 2) begin
                hif.req   = 1'b1;
                hif.addr  = 16'hBEEF;
                hif.wdata = 32'h0BAD_0BAD;
            end
            if (toggle && k == 3) begin
                chk("strobe_addr_held", 32'(mc_addr), 32'(a));
                hif.req = 1'b0;
            end
            if (hif.done === 1'b1) got = 1'b1;
        end
        t_done = cyc_cnt;
        chk("done_seen", 32'(got), 32'd1);
        got_e = sb_q.pop_front();
        if (got) begin
            chk("rdata", hif.rdata, got_e.rdata);
            chk("err", 32'(hif.err), 32'(got_e.err));
            chk("latency", 32'(k), 32'(got_e.lat));
        end
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"},    32'(mc_cs_), 32'd1);
        chk({tag, "_we"},    32'(mc_we_), 32'd1);
        chk({tag, "_oe"},    32'(mc_oe_), 32'd1);
        chk({tag, "_addr"},  32'(mc_addr), 32'd0);
        chk({tag, "_dq"},    mc_dq, 32'hzzzz_zzzz);
        chk({tag, "_busy"},  32'(hif.busy), 32'd0);
        chk({tag, "_done"},  32'(hif.done), 32'd0);
        chk({tag, "_err"},   32'(hif.err), 32'd0);
        chk({tag, "_rdata"}, hif.rdata, 32'd0);
    endtask

    int unsigned t1, t2, t3, s0, dc0;

    initial begin
        hif.req   = 1'b0;
        hif.we    = 1'b0;
        hif.addr  = '0;
        hif.wdata = '0;
        #1 rst_ = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read back
        access(1'b1, 16'h0012, 32'hDEAD_BEEF, exp_last, 1'b0, 6, 0, 0, t1);
        chk("wr_cs_len", 32'(last_cs_len), 32'd5);
        chk("wr_we_len", 32'(last_we_len), 32'd5);
        exp_last = 32'hDEAD_BEEF;
        access(1'b0, 16'h0012, '0, exp_last, 1'b0, 7, 0, 0, t1);
        chk("rd_cs_len", 32'(last_cs_len), 32'd6);

        // Late acknowledge first seen in cycle 9
        ack_from = 9;
        access(1'b0, 16'h0012, '0, 32'hDEAD_BEEF, 1'b0, 10, 0, 0, t1);
        chk("late_cs_len", 32'(last_cs_len), 32'd9);

        // No acknowledge at all: abort after 64 strobe cycles, rdata kept
        ack_from = 1000;
        access(1'b0, 16'h0001, '0, exp_last, 1'b1, 65, 0, 0, t1);
        chk("to_cs_len", 32'(last_cs_len), 32'd64);
        ack_from = 4;

        // Back-to-back reads with req held high
        access(1'b0, 16'h0001, '0, init_val(8'h01), 1'b0, 7, 1, 0, t1);
        access(1'b0, 16'h0002, '0, init_val(8'h02), 1'b0, 7, 1, 0, t2);
        chk("b2b_gap1", 32'(last_gap), 32'd2);
        access(1'b0, 16'h0003, '0, init_val(8'h03), 1'b0, 7, 0, 0, t3);
        chk("b2b_gap2", 32'(last_gap), 32'd2);
        chk("b2b_period1", 32'(t2 - t1), 32'd8);
        chk("b2b_period2", 32'(t3 - t2), 32'd8);
        exp_last = init_val(8'h03);

        // req/addr/wdata toggled during a write strobe
        s0 = n_strobes;
        access(1'b1, 16'h0030, 32'h1234_5678, exp_last, 1'b0, 6, 0, 1, t1);
        repeat (4) @(negedge clk);
        #1;
        chk("toggle_no_extra", 32'(n_strobes - s0), 32'd1);
        chk("toggle_idle", 32'(hif.busy), 32'd0);
        access(1'b0, 16'h0030, '0, 32'h1234_5678, 1'b0, 7, 0, 0, t1);
        access(1'b0, 16'hBEEF, '0, init_val(8'hEF), 1'b0, 7, 0, 0, t1);

        // Asynchronous reset in the middle of a write strobe
        dc0 = done_cnt;
        hif.req   = 1'b1;
        hif.we    = 1'b1;
        hif.addr  = 16'h0040;
        hif.wdata = 32'h55AA_55AA;
        @(posedge clk);
        @(negedge clk);
        hif.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_dq", mc_dq, 32'h55AA_55AA);
        #2 rst_ = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst_ = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("rst_idle", 32'(hif.busy), 32'd0);
        access(1'b0, 16'h0040, '0, init_val(8'h40), 1'b0, 7, 0, 0, t1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_cs_ctrl.md
# sync_cs_ctrl

Initiator-side controller for the synchronous chip-select memory bus: it turns single-word host requests into `cs_`/`we_`/`oe_` strobes, drives or captures the 32-bit data bus, and waits for the device acknowledge. It sits between the internal request path of the memory controller and an external synchronous CS device. Its timing is matched to the device model's fixed read, write and acknowledge latencies. It also terminates any access the device fails to acknowledge within a bounded time.

## Interface
- `RD_LAT`, 6: strobe cycle (1-based) at whose closing edge read data is captured; legal range 1..TO_CYC-1.
- `WR_LAT`, 5: minimum strobe length in cycles for writes; legal range 1..TO_CYC-1.
- `TO_CYC`, 64: strobe cycles allowed without acknowledge before abort.
- `clk` in 1: single clock, all state on rising edge.
- `rst_` in 1: asynchronous, active-low reset.
- `req` in 1: host request, sampled only in IDLE.
- `we` in 1: 1 = write, 0 = read; captured with `req`.
- `addr` in 16: word address; captured with `req`.
- `wdata` in 32: write data; captured with `req`.
- `busy` out 1: access in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high with `done` when the access timed out.
- `rdata` out 32: captured read data, valid from `done` until next read completes.
- `mc_addr` out 16: device address.
- `mc_dq` inout 32: device data bus; driven only during write strobes.
- `mc_cs_` out 1: chip select, active low.
- `mc_we_` out 1: write enable, active low.
- `mc_oe_` out 1: output enable, active low.
- `mc_ack_` in 1: device acknowledge; asserted when HIGH, as driven by the device.

## Operation
- Reset values: `mc_cs_`=1, `mc_we_`=1, `mc_oe_`=1, `mc_addr`=0, `mc_dq`=Z, `busy`=0, `done`=0, `err`=0, `rdata`=0.
- States: IDLE, STROBE, RECOVER.
- IDLE:
  - `req`=1 at a rising edge latches `we`/`addr`/`wdata`, clears the cycle counter and the sticky ack flag, and moves to STROBE.
  - `busy` rises on that edge.
- STROBE:
  - `mc_cs_`=0 and `mc_addr` = the latched address, both held constant for the whole strobe.
  - Read: `mc_oe_`=0, `mc_we_`=1, `mc_dq`=Z.
  - Write: `mc_we_`=0, `mc_oe_`=1, `mc_dq` = the latched wdata, driven from the first strobe cycle to the last.
  - Counter `n` = 1 in the first strobe cycle and increments each cycle. Counter width must hold TO_CYC.
  - Ack flag sets on any edge sampling `mc_ack_`=1 and stays set.
  - Read: `rdata` is loaded from `mc_dq` at the closing edge of cycle `n`=RD_LAT.
  - Leave STROBE at the closing edge of the first cycle where the ack flag (including the current sample) is set AND `n` ≥ LAT, where LAT = RD_LAT for reads and WR_LAT for writes.
  - Timeout: if `n`=TO_CYC and the ack flag is still clear, leave STROBE and set the error.
- RECOVER (exactly one cycle):
  - All strobes high and `mc_dq` released.
  - `done`=1; `err`=1 only on timeout. On a timed-out read, `rdata` keeps its prior value.
  - `busy` falls at the closing edge.
  - Return to IDLE.
- `req` is ignored while `busy`=1; no request queuing.
- Asynchronous reset mid-access: all outputs go to their reset values immediately, the bus is released at once, no `done` is issued, and the in-flight access is lost.

## Timing
- Matched device behaviour:
  - Acknowledge is visible from strobe cycle 4.
  - Read data is driven from cycle 6.
  - Write is committed at the closing edge of cycle 5.
- Default read: strobe cycles 1–6, capture at the end of cycle 6, `done` in cycle 7.
  - `req` edge to `done` = 7 cycles.
- Default write: strobe cycles 1–5, `done` in cycle 6.
- Late acknowledge first seen in cycle k > LAT: the strobe ends after cycle k.
  - A read still captures at cycle RD_LAT.
- Consecutive strobes are always separated by ≥2 cs_-high cycles (RECOVER + IDLE).
  - This guarantees the device's shift registers clear between accesses.
- `req` held high continuously yields one access per 8 cycles for reads and one per 7 for writes.

## Test plan
- Reset: hold `rst_`=0 mid-STROBE → all outputs at reset values, `mc_dq`=Z within the same cycle, no `done` after release.
- Write then read against the device model:
  - Write addr 0x0012, data 0xDEADBEEF → `mc_we_` low for exactly 5 cycles, `done`=1, `err`=0.
  - Read of 0x0012 → `rdata`=0xDEADBEEF, `done` 7 cycles after `req`.
- Late acknowledge: bench holds `mc_ack_` low until strobe cycle 9 on a read.
  - Required: `mc_cs_` low for 9 cycles.
  - Required: `rdata` = value on `mc_dq` at cycle 6.
  - Required: `done` in cycle 10.
- Timeout: `mc_ack_` tied low, TO_CYC=64 → strobe of 64 cycles, `done`=1 and `err`=1 together, `rdata` unchanged.
- Back-to-back: `req` held high for 3 reads to 0x0001, 0x0002, 0x0003.
  - Required: three `done` pulses 8 cycles apart.
  - Required: ≥2 cs_-high cycles between strobes.
  - Required: correct data for each read.
- `req` toggled during STROBE → no extra access started, latched `addr` and `wdata` unaffected.
